// File: rtl/am_env_dac.sv
// am_env_dac
// Converts the squared-and-filtered AM envelope from the upstream FIR into an
// offset-binary DAC word. Every DECIM cycles one sample is captured, its
// floor square root is found bit-serially (MSB first, 7 cycles), a slow DC
// tracker is subtracted, and the AC part is gained, offset to mid-scale and
// saturated into the 14-bit DAC range.
//
// Parameters
//   DECIM      sample-capture period in sys_clk cycles (>= 10)
//   DC_SHIFT   DC-tracker time constant, as a power of two (in samples)
//   GAIN_SHIFT AC gain, as a left shift applied before the mid-scale offset
//
// Ports
//   sys_clk     in   1  clock, all state changes on its rising edge
//   sys_rst_n   in   1  asynchronous active-low reset
//   fir_out     in  14  signed squared envelope from the FIR
//   da_data     out 14  unsigned offset-binary DAC word, mid-scale 8192
//   sample_tick out  1  one-cycle pulse when da_data takes a new value
module am_env_dac #(
  parameter int DECIM      = 16,
  parameter int DC_SHIFT   = 6,
  parameter int GAIN_SHIFT = 6
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic signed [13:0] fir_out,
  output logic        [13:0] da_data,
  output logic               sample_tick
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  // Holds root << DC_SHIFT at steady state, one spare bit of headroom.
  localparam int ACC_W = 7 + DC_SHIFT + 1;
  localparam int DCE_W = ACC_W - DC_SHIFT;
  // root (0..127) minus dc_est (0..2^DCE_W-1) as a signed value.
  localparam int AC_W  = DCE_W + 2;
  localparam int V_W   = AC_W + GAIN_SHIFT + 2;

  typedef enum logic [1:0] {IDLE, CALC, POST, OUT} state_t;

  state_t                   state;
  logic        [CNT_W-1:0]  cnt;
  logic        [12:0]       x_p0;
  logic        [6:0]        root_p1;
  logic        [2:0]        bit_idx;
  logic signed [AC_W-1:0]   ac_p2;
  logic        [ACC_W-1:0]  dc_acc;

  logic        [6:0]        trial;
  logic        [13:0]       trial_sq;
  logic        [DCE_W-1:0]  dc_est;
  logic signed [AC_W-1:0]   ac_next;
  logic        [ACC_W-1:0]  dc_acc_next;
  logic signed [V_W-1:0]    ac_ext;
  logic signed [V_W-1:0]    v_full;

  // Negative envelope values are treated as silence.
  function automatic logic [12:0] clamp_neg(input logic signed [13:0] s);
    clamp_neg = s[13] ? 13'd0 : s[12:0];
  endfunction

  function automatic logic [13:0] sat_dac(input logic signed [V_W-1:0] v);
    if (v < $signed(V_W'(0)))
      sat_dac = 14'd0;
    else if (v > $signed(V_W'(16383)))
      sat_dac = 14'd16383;
    else
      sat_dac = v[13:0];
  endfunction

  always_comb begin
    trial       = root_p1 | (7'd1 << bit_idx);
    trial_sq    = 14'(trial) * 14'(trial);
    dc_est      = dc_acc[ACC_W-1:DC_SHIFT];
    ac_next     = $signed(AC_W'(root_p1)) - $signed(AC_W'(dc_est));
    // dc_acc >= dc_est always, so this never wraps below zero.
    dc_acc_next = dc_acc + ACC_W'(root_p1) - ACC_W'(dc_est);
    ac_ext      = {{(V_W-AC_W){ac_p2[AC_W-1]}}, ac_p2};
    v_full      = (ac_ext <<< GAIN_SHIFT) + $signed(V_W'(8192));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt         <= '0;
      state       <= IDLE;
      x_p0        <= '0;
      root_p1     <= '0;
      bit_idx     <= '0;
      ac_p2       <= '0;
      dc_acc      <= '0;
      da_data     <= 14'd8192;
      sample_tick <= 1'b0;
    end else begin
      cnt         <= (cnt == CNT_W'(DECIM - 1)) ? '0 : cnt + 1'b1;
      sample_tick <= 1'b0;
      case (state)
        // Capture stage: a capture point outside IDLE is simply not seen.
        IDLE: begin
          if (cnt == '0) begin
            x_p0    <= clamp_neg(fir_out);
            root_p1 <= '0;
            bit_idx <= 3'd6;
            state   <= CALC;
          end
        end
        // Square-root stage: keep the trial bit if trial^2 still fits under x.
        CALC: begin
          if (trial_sq <= {1'b0, x_p0})
            root_p1 <= trial;
          if (bit_idx == 3'd0)
            state <= POST;
          else
            bit_idx <= bit_idx - 3'd1;
        end
        // DC-removal stage.
        POST: begin
          ac_p2  <= ac_next;
          dc_acc <= dc_acc_next;
          state  <= OUT;
        end
        // Output stage.
        OUT: begin
          da_data     <= sat_dac(v_full);
          sample_tick <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am_env_dac.sv
module tb_am_env_dac;

  logic               clk;
  logic               rst_n;
  logic signed [13:0] fir;
  logic        [13:0] da;
  logic               tick;

  logic               rst8_n;
  logic signed [13:0] fir8;
  logic        [13:0] da8;
  logic               tick8;

  int checks;
  int errors;

  am_env_dac dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .fir_out     (fir),
    .da_data     (da),
    .sample_tick (tick)
  );

  am_env_dac #(.DECIM(16), .DC_SHIFT(6), .GAIN_SHIFT(8)) dut8 (
    .sys_clk     (clk),
    .sys_rst_n   (rst8_n),
    .fir_out     (fir8),
    .da_data     (da8),
    .sample_tick (tick8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [13:0] fir;
    int                 exp_da;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Counts rising edges until the selected tick is seen (#1 after the edge);
  // returns -1 if the limit expires.
  task automatic wait_tick(input bit use8, input int limit, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= limit && !found; i++) begin
      @(posedge clk);
      #1;
      if (use8 ? tick8 : tick) begin
        n = i;
        found = 1'b1;
      end
    end
  endtask

  // Reset the default instance with a given input, release on a falling edge
  // so the next rising edge is the first capture.
  task automatic reset_main(input logic signed [13:0] val);
    @(negedge clk);
    rst_n = 1'b0;
    fir = val;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int prev;
    int viol;
    int tmo;

    checks = 0;
    errors = 0;

    vecs[0] = '{14'sd4096,  12288};
    vecs[1] = '{14'sd1000,  10176};
    vecs[2] = '{-14'sd100,  8192};
    vecs[3] = '{14'sd0,     8192};
    vecs[4] = '{14'sd8191,  13952};
    vecs[5] = '{14'sd1,     8256};
    vecs[6] = '{14'sd3,     8256};
    vecs[7] = '{14'sd4,     8320};
    vecs[8] = '{14'sd8100,  13952};
    vecs[9] = '{14'sd8099,  13888};

    rst_n  = 1'b0;
    rst8_n = 1'b0;
    fir    = 14'sd5000;
    fir8   = 14'sd8191;

    // Reset hold with a nonzero input.
    tmo = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (da != 14'd8192 || tick != 1'b0) tmo++;
    end
    check("reset_hold_bad_cycles", tmo, 0);
    check("reset_da", int'(da), 8192);
    check("reset_da8", int'(da8), 8192);

    // Table: first tick latency and value from a fresh reset.
    foreach (vecs[k]) begin
      reset_main(vecs[k].fir);
      wait_tick(1'b0, 40, n);
      check($sformatf("latency_vec%0d", k), n - 1, 9);
      check($sformatf("first_da_vec%0d", k), int'(da), vecs[k].exp_da);
    end

    // Negative input: every tick stays at mid-scale.
    reset_main(-14'sd100);
    for (int i = 0; i < 4; i++) begin
      wait_tick(1'b0, 40, n);
      check($sformatf("neg_tick%0d", i), int'(da), 8192);
    end

    // Tick spacing with fir=1000.
    reset_main(14'sd1000);
    wait_tick(1'b0, 40, n);
    check("spacing_first_da", int'(da), 10176);
    for (int i = 0; i < 50; i++) begin
      wait_tick(1'b0, 40, n);
      check($sformatf("spacing%0d", i), n, 16);
    end

    // Constant 4096: DC tracker decay toward mid-scale.
    reset_main(14'sd4096);
    wait_tick(1'b0, 40, n);
    check("decay_t0", int'(da), 12288);
    wait_tick(1'b0, 40, n);
    check("decay_t1", int'(da), 12224);
    // da_data holds between ticks.
    repeat (5) @(posedge clk);
    #1;
    check("decay_hold", int'(da), 12224);
    wait_tick(1'b0, 40, n);
    check("decay_t2", int'(da), 12224);
    wait_tick(1'b0, 40, n);
    check("decay_t3", int'(da), 12160);
    prev = int'(da);
    viol = 0;
    tmo = 0;
    for (int i = 0; i < 2000; i++) begin
      wait_tick(1'b0, 40, n);
      if (n < 0) tmo++;
      if (int'(da) > prev) viol++;
      prev = int'(da);
    end
    check("decay_timeouts", tmo, 0);
    check("decay_monotonic_viol", viol, 0);
    check("decay_within_64", int'(da >= 14'd8192 && da <= 14'd8256), 1);

    // Reset pulse three cycles into CALC.
    wait_tick(1'b0, 40, n);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midcalc_da", int'(da), 8192);
    check("midcalc_tick", int'(tick), 0);
    @(negedge clk);
    check("midcalc_tick_held", int'(tick), 0);
    rst_n = 1'b1;
    wait_tick(1'b0, 40, n);
    check("midcalc_latency", n - 1, 9);
    check("midcalc_da_dc_cleared", int'(da), 12288);

    // GAIN_SHIFT=8: positive and negative saturation.
    @(negedge clk);
    rst8_n = 1'b1;
    wait_tick(1'b1, 40, n);
    check("g8_latency", n - 1, 9);
    check("g8_sat_high", int'(da8), 16383);
    fir8 = 14'sd4096;
    tmo = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_tick(1'b1, 40, n);
      if (n < 0) tmo++;
    end
    check("g8_settle_timeouts", tmo, 0);
    check("g8_settled", int'(da8), 8192);
    fir8 = 14'sd0;
    wait_tick(1'b1, 40, n);
    check("g8_sat_low", int'(da8), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
